soc_system_pio_in_edge: RTL and testbench
=========================================

SOC_SYSTEM_PIO_IN_EDGE -- requirements
Module: soc_system_pio_in_edge

Interface
REQ-001 Parameter WIDTH, default 8: number of input bits, legal range 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth, legal range 2..4.
REQ-003 Parameter EDGE_TYPE, default 0: capture mode, 0=rising, 1=falling, 2=any.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL be on its rising edge.
REQ-005 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port address, input, 2 bits: Avalon-MM slave register address.
REQ-007 Port chipselect, input, 1 bit: slave select.
REQ-008 Port write_n, input, 1 bit: active-low write strobe, qualified by chipselect.
REQ-009 Port writedata, input, 32 bits: write data.
REQ-010 Port in_port, input, WIDTH bits: asynchronous external inputs.
REQ-011 Port readdata, output, 32 bits: registered read data.
REQ-012 Port irq, output, 1 bit: level interrupt, active-high.

Function
REQ-013 Register map: 0=DATA (read-only), 1=reserved (reads 0, writes ignored), 2=IRQMASK (R/W), 3=EDGECAP (read; write-1-to-clear).
REQ-014 in_port SHALL pass through SYNC_STAGES flops to give sync_in; a change that precedes clock edge t SHALL appear on sync_in after edge t+SYNC_STAGES-1.
REQ-015 prev_in SHALL equal sync_in delayed by one cycle.
REQ-016 Edge per bit: rising = sync_in & ~prev_in; falling = ~sync_in & prev_in; any = XOR, selected by EDGE_TYPE.
REQ-017 A detected edge SHALL set its EDGECAP bit on the next clock edge, and the bit SHALL stay set until it is cleared.
REQ-018 A write to address 3 with chipselect=1 and write_n=0 SHALL clear each EDGECAP bit whose writedata bit is 1.
REQ-019 If a new edge and a clear hit the same bit in the same cycle, the bit SHALL end up set (the edge wins).
REQ-020 A write to address 2 SHALL load IRQMASK from writedata[WIDTH-1:0] on the next clock edge.
REQ-021 irq SHALL equal the OR-reduction of (EDGECAP & IRQMASK), driven combinationally from those registers; there is no extra latency after the register update.
REQ-022 readdata SHALL update every clock edge with the addressed value, giving 1-cycle read latency, with no chipselect/read qualification.
REQ-023 Address 0 returns sync_in; address 2 returns IRQMASK; address 3 returns EDGECAP; address 1 returns 0.
REQ-024 All readdata bits at and above WIDTH SHALL read 0.
REQ-025 writedata bits at and above WIDTH SHALL be ignored.
REQ-026 A write to address 0 or 1 SHALL have no effect.
REQ-027 An illegal parameter value SHALL stop elaboration with an error.

Reset
REQ-028 While reset_n=0, the sync flops, prev_in, EDGECAP, IRQMASK and readdata SHALL be 0, and irq SHALL be 0.
REQ-029 Reset asserted mid-operation SHALL immediately discard pending edges and the mask.
REQ-030 After reset release, an input already high SHALL be reported as a rising edge once it propagates, because prev_in resets to 0; this behaviour is intended.

Structure
REQ-031 Package soc_system_pio_pkg SHALL hold: the address constants ADDR_DATA=0, ADDR_IRQMASK=2, ADDR_EDGECAP=3; the edge-type constants EDGE_RISE, EDGE_FALL, EDGE_ANY; and DATA_W=32.
REQ-032 Sub-module soc_system_pio_sync (parameters WIDTH and STAGES, with async reset) SHALL implement the synchronizer; everything else SHALL be flat in this module.

Verification
REQ-033 Reset check: reset_n=0 with in_port=all-ones -> readdata=0 and irq=0; after release, EDGECAP=0xFF two cycles after sync_in rises (WIDTH=8, rising).
REQ-034 Latency check: in_port 0x00->0x5A before edge t -> a read of address 0 issued at edge t+2 returns 0x5A at t+3; EDGECAP=0x5A from t+2.
REQ-035 Interrupt check: IRQMASK=0x01, rising edge on bit0 -> irq=1; write 0x01 to address 3 -> irq=0 the next cycle.
REQ-036 Collision check: clear bit3 in the same cycle that a new bit3 edge is detected -> EDGECAP[3] stays 1 and irq stays asserted.
REQ-037 Falling mode: EDGE_TYPE=1, pulse bit7 1->0 -> EDGECAP=0x80; the 0->1 transition alone leaves EDGECAP=0.
REQ-038 Width check: WIDTH=32 with EDGE_TYPE=2 toggling every bit -> EDGECAP=0xFFFFFFFF; WIDTH=5 -> readdata[31:5]=0 at every address.

Source files
------------

// File: rtl/soc_system_pio_pkg.sv
// soc_system_pio_pkg: shared register map, edge modes and bus width for the PIO edge-capture block
package soc_system_pio_pkg;
  localparam int DATA_W = 32;
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;
endpackage

// File: rtl/soc_system_pio_sync.sv
// soc_system_pio_sync: multi-flop synchronizer bringing asynchronous inputs into the clk domain
module soc_system_pio_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [STAGES-1:0][WIDTH-1:0] ff;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ff <= '0;
    else ff <= {ff[STAGES-2:0], d};
  assign q = ff[STAGES-1];
endmodule

// File: rtl/soc_system_pio_in_edge.sv
// soc_system_pio_in_edge: Avalon-MM input PIO with edge capture, write-1-to-clear and masked level irq
module soc_system_pio_in_edge
  import soc_system_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  input  logic [WIDTH-1:0]  in_port,
  output logic [31:0]       readdata,
  output logic              irq
);
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("soc_system_pio_in_edge: WIDTH must be 1..32");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
    $error("soc_system_pio_in_edge: SYNC_STAGES must be 2..4");
  end
  if (EDGE_TYPE < EDGE_RISE || EDGE_TYPE > EDGE_ANY) begin : g_bad_edge
    $error("soc_system_pio_in_edge: EDGE_TYPE must be 0..2");
  end
  logic [WIDTH-1:0] sync_in, prev_in, edge_cap, irq_mask, edges, clr, rd_sel;
  logic wr;
  soc_system_pio_sync #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .reset_n(reset_n), .d(in_port), .q(sync_in)
  );
  assign wr = chipselect && !write_n;
  always_comb begin
    edges  = EDGE_TYPE == EDGE_RISE ? sync_in & ~prev_in :
             EDGE_TYPE == EDGE_FALL ? ~sync_in & prev_in : sync_in ^ prev_in;
    clr    = wr && address == ADDR_EDGECAP ? writedata[WIDTH-1:0] : '0;
    rd_sel = address == ADDR_DATA    ? sync_in  :
             address == ADDR_IRQMASK ? irq_mask :
             address == ADDR_EDGECAP ? edge_cap : '0;
  end
  // a fresh edge is OR-ed in after the clear, so it survives a same-cycle clear
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      prev_in  <= '0;
      edge_cap <= '0;
      irq_mask <= '0;
      readdata <= '0;
    end else begin
      prev_in  <= sync_in;
      edge_cap <= (edge_cap & ~clr) | edges;
      if (wr && address == ADDR_IRQMASK) irq_mask <= writedata[WIDTH-1:0];
      readdata <= DATA_W'(rd_sel);
    end
  assign irq = |(edge_cap & irq_mask);
endmodule

// File: tb/tb_soc_system_pio_in_edge.sv
// tb_soc_system_pio_in_edge: four parameterisations driven on a shared bus and checked against a history-based model
module tb_soc_system_pio_in_edge;
  localparam int H = 64;
  localparam int WS[4] = '{8, 8, 32, 5};
  localparam int SS[4] = '{2, 2, 2, 3};
  localparam int ET[4] = '{0, 1, 2, 2};
  logic clk = 0, reset_n = 0, chipselect = 0, write_n = 1;
  logic [1:0] address = 0;
  logic [31:0] writedata = 0;
  logic [31:0] inp[4];
  logic [31:0] rd[4];
  logic irq_o[4];
  logic [31:0] samp[4][H];
  logic [31:0] mcap[4], mmask[4], mrd[4];
  int n = 0, errors = 0, checks = 0;
  always #5 clk = ~clk;

  soc_system_pio_in_edge #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(inp[0][7:0]), .readdata(rd[0]), .irq(irq_o[0]));
  soc_system_pio_in_edge #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(inp[1][7:0]), .readdata(rd[1]), .irq(irq_o[1]));
  soc_system_pio_in_edge #(.WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(inp[2]), .readdata(rd[2]), .irq(irq_o[2]));
  soc_system_pio_in_edge #(.WIDTH(5), .SYNC_STAGES(3), .EDGE_TYPE(2)) dut3 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(inp[3][4:0]), .readdata(rd[3]), .irq(irq_o[3]));

  function automatic logic [31:0] wmask(int w);
    return w == 32 ? 32'hFFFF_FFFF : (32'd1 << w) - 32'd1;
  endfunction

  // sync_in seen after clock edge k (edges counted from reset release) is the pin value sampled SYNC_STAGES-1 edges earlier
  function automatic logic [31:0] sync_at(int d, int k);
    int j;
    j = k - SS[d] + 1;
    return (k < 0 || j < 0) ? 32'd0 : samp[d][j % H];
  endfunction

  // one clock: advance the model at the rising edge, return at the falling edge for driving and sampling
  task automatic tick;
    @(posedge clk);
    if (!reset_n) begin
      n = 0;
      for (int d = 0; d < 4; d++) begin mcap[d] = 0; mmask[d] = 0; mrd[d] = 0; end
    end else begin
      for (int d = 0; d < 4; d++) begin
        logic [31:0] sy, pv, ed, wm, clr;
        wm = wmask(WS[d]);
        samp[d][n % H] = inp[d] & wm;
        sy = sync_at(d, n - 1);
        pv = sync_at(d, n - 2);
        ed = (ET[d] == 0 ? sy & ~pv : ET[d] == 1 ? ~sy & pv : sy ^ pv) & wm;
        mrd[d] = address == 2'd0 ? sy : address == 2'd2 ? mmask[d] : address == 2'd3 ? mcap[d] : 32'd0;
        clr = (chipselect && !write_n && address == 2'd3) ? writedata & wm : 32'd0;
        if (chipselect && !write_n && address == 2'd2) mmask[d] = writedata & wm;
        mcap[d] = (mcap[d] & ~clr) | ed;
      end
      n++;
    end
    @(negedge clk);
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] v);
    chipselect = 1; write_n = 0; address = a; writedata = v;
    tick();
    chipselect = 0; write_n = 1; writedata = $urandom;
  endtask

  task automatic set_all(input logic [31:0] v);
    for (int d = 0; d < 4; d++) inp[d] = v;
  endtask

  task automatic test_reset;
    reset_n = 0; set_all(32'hFFFF_FFFF); address = 2'd3;
    repeat (3) tick();
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (rd[d] !== 32'd0 || irq_o[d] !== 1'b0) begin
        errors++; $display("FAIL reset dut%0d readdata=%h irq=%b required 00000000/0", d, rd[d], irq_o[d]);
      end
    end
    reset_n = 1;
    repeat (4) begin
      tick();
      for (int d = 0; d < 4; d++) begin
        checks++;
        if (rd[d] !== mrd[d] || irq_o[d] !== |(mcap[d] & mmask[d])) begin
          errors++; $display("FAIL reset_release dut%0d readdata=%h irq=%b required %h/%b", d, rd[d], irq_o[d], mrd[d], |(mcap[d] & mmask[d]));
        end
      end
    end
    checks++;
    if (rd[0] !== 32'h0000_00FF) begin
      errors++; $display("FAIL reset_edgecap readdata=%h required 000000ff", rd[0]);
    end
  endtask

  task automatic test_latency;
    set_all(0); address = 2'd0;
    repeat (5) tick();
    bus_wr(2'd3, 32'hFFFF_FFFF);
    address = 2'd0;
    repeat (4) tick();
    set_all(32'h0000_005A);
    for (int i = 1; i <= 3; i++) begin
      tick();
      for (int d = 0; d < 4; d++) begin
        checks++;
        if (rd[d] !== mrd[d] || irq_o[d] !== |(mcap[d] & mmask[d])) begin
          errors++; $display("FAIL latency dut%0d cyc%0d readdata=%h irq=%b required %h/%b", d, i, rd[d], irq_o[d], mrd[d], |(mcap[d] & mmask[d]));
        end
      end
      checks++;
      if (rd[0] !== (i == 3 ? 32'h5A : 32'h0)) begin
        errors++; $display("FAIL latency_data cyc%0d readdata=%h required %h", i, rd[0], i == 3 ? 32'h5A : 32'h0);
      end
    end
    address = 2'd3;
    tick();
    checks++;
    if (rd[0] !== 32'h5A) begin
      errors++; $display("FAIL latency_edgecap readdata=%h required 0000005a", rd[0]);
    end
  endtask

  task automatic test_irq;
    set_all(0);
    bus_wr(2'd2, 32'h1);
    repeat (4) tick();
    bus_wr(2'd3, 32'hFFFF_FFFF);
    tick();
    checks++;
    if (irq_o[0] !== 1'b0) begin errors++; $display("FAIL irq_idle irq=%b required 0", irq_o[0]); end
    set_all(32'h1);
    repeat (4) begin
      tick();
      for (int d = 0; d < 4; d++) begin
        checks++;
        if (irq_o[d] !== |(mcap[d] & mmask[d])) begin
          errors++; $display("FAIL irq_model dut%0d irq=%b required %b", d, irq_o[d], |(mcap[d] & mmask[d]));
        end
      end
    end
    checks++;
    if (irq_o[0] !== 1'b1) begin errors++; $display("FAIL irq_set irq=%b required 1", irq_o[0]); end
    bus_wr(2'd3, 32'h1);
    checks++;
    if (irq_o[0] !== 1'b0) begin errors++; $display("FAIL irq_clear irq=%b required 0", irq_o[0]); end
  endtask

  task automatic test_collision;
    set_all(0);
    bus_wr(2'd2, 32'h8);
    repeat (4) tick();
    set_all(32'h8);
    repeat (4) tick();
    set_all(0);
    repeat (4) tick();
    checks++;
    if (irq_o[0] !== 1'b1) begin errors++; $display("FAIL collision_pre irq=%b required 1", irq_o[0]); end
    set_all(32'h8);
    tick();
    tick();
    bus_wr(2'd3, 32'h8);
    checks++;
    if (irq_o[0] !== 1'b1) begin errors++; $display("FAIL collision_irq irq=%b required 1", irq_o[0]); end
    address = 2'd3;
    tick();
    checks++;
    if (rd[0][3] !== 1'b1) begin errors++; $display("FAIL collision_cap edgecap=%h required bit3 set", rd[0]); end
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (rd[d] !== mrd[d] || irq_o[d] !== |(mcap[d] & mmask[d])) begin
        errors++; $display("FAIL collision_model dut%0d readdata=%h irq=%b required %h/%b", d, rd[d], irq_o[d], mrd[d], |(mcap[d] & mmask[d]));
      end
    end
  endtask

  task automatic test_falling;
    set_all(0);
    repeat (4) tick();
    bus_wr(2'd3, 32'hFFFF_FFFF);
    address = 2'd3;
    set_all(32'h80);
    repeat (5) tick();
    checks++;
    if (rd[1] !== 32'd0) begin errors++; $display("FAIL falling_rise edgecap=%h required 00000000", rd[1]); end
    set_all(0);
    repeat (5) tick();
    checks++;
    if (rd[1] !== 32'h80) begin errors++; $display("FAIL falling_fall edgecap=%h required 00000080", rd[1]); end
  endtask

  task automatic test_width;
    set_all(32'hA5A5_A5A5);
    repeat (5) tick();
    bus_wr(2'd3, 32'hFFFF_FFFF);
    bus_wr(2'd2, 32'hFFFF_FFFF);
    set_all(32'h5A5A_5A5A);
    address = 2'd3;
    repeat (5) tick();
    checks++;
    if (rd[2] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL width32_cap edgecap=%h required ffffffff", rd[2]); end
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      inp[3] = $urandom;
      tick();
      checks++;
      if (rd[3][31:5] !== 27'd0) begin errors++; $display("FAIL width5_upper addr%0d readdata=%h required upper bits 0", a, rd[3]); end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 300; i++) begin
      for (int d = 0; d < 4; d++) inp[d] = ($urandom_range(0, 3) == 0) ? $urandom : inp[d];
      chipselect = 1'($urandom_range(0, 1));
      write_n = 1'($urandom_range(0, 1));
      address = 2'($urandom_range(0, 3));
      writedata = $urandom;
      tick();
      for (int d = 0; d < 4; d++) begin
        checks++;
        if (rd[d] !== mrd[d] || irq_o[d] !== |(mcap[d] & mmask[d])) begin
          errors++; $display("FAIL random dut%0d it%0d readdata=%h irq=%b required %h/%b", d, i, rd[d], irq_o[d], mrd[d], |(mcap[d] & mmask[d]));
        end
      end
    end
    chipselect = 0; write_n = 1;
  endtask

  task automatic test_reset_mid;
    bus_wr(2'd2, 32'hFFFF_FFFF);
    set_all(32'hFFFF_FFFF);
    address = 2'd2;
    repeat (5) tick();
    #2 reset_n = 0;
    #1;
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (rd[d] !== 32'd0 || irq_o[d] !== 1'b0) begin
        errors++; $display("FAIL reset_mid dut%0d readdata=%h irq=%b required 00000000/0", d, rd[d], irq_o[d]);
      end
    end
    tick();
    reset_n = 1;
    set_all(0);
    repeat (6) begin
      tick();
      for (int d = 0; d < 4; d++) begin
        checks++;
        if (rd[d] !== mrd[d] || irq_o[d] !== |(mcap[d] & mmask[d])) begin
          errors++; $display("FAIL reset_mid_after dut%0d readdata=%h irq=%b required %h/%b", d, rd[d], irq_o[d], mrd[d], |(mcap[d] & mmask[d]));
        end
      end
    end
  endtask

  initial begin
    set_all(0);
    for (int d = 0; d < 4; d++) begin mcap[d] = 0; mmask[d] = 0; mrd[d] = 0; end
    @(negedge clk);
    test_reset();
    test_latency();
    test_irq();
    test_collision();
    test_falling();
    test_width();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
